simple_serializer: RTL and testbench
====================================

// Module: simple_serializer
// PURPOSE
//  Transmit end of a 1-bit serial link: parallel-in, serial-out shifter.
//  Accepts a WIDTH-bit word via valid/ready and drives it one bit per clk
//  posedge on out_1, framed by out_valid/out_last.
//  Sits upstream of a single-flop capture stage or deserializer on the link.
// PARAMETERS
//  WIDTH      8   data bits per frame; legal range 1..32
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk       in   1      rising-edge clock; the only clock
//  rst_n     in   1      asynchronous reset, active-low
//  in_valid  in   1      in_data is valid
//  in_ready  out  1      block can accept a word this cycle
//  in_data   in   WIDTH  parallel word to send
//  out_1     out  1      serial data bit
//  out_valid out  1      out_1 carries a frame bit this cycle
//  out_last  out  1      final bit of the current frame
// BEHAVIOUR
//  - Reset: asynchronous assert, synchronous deassert seen at next posedge.
//    Reset values: out_1=0, out_valid=0, out_last=0, state=IDLE, count=0.
//    in_ready is 1 during reset (IDLE).
//  - All of out_1, out_valid and out_last are registered. in_ready is
//    decoded from the state register; no combinational in->out path.
//  - Accept: an edge with in_valid&&in_ready loads the shift register and
//    count. in_data is ignored on any edge without accept.
//  - Latency: the first bit appears on out_1 in the cycle after accept.
//    A frame is WIDTH consecutive cycles with out_valid=1 (WIDTH+1 with
//    parity enabled).
//  - FSM:
//    IDLE  : in_ready=1, out_valid=0. Accept -> SHIFT.
//    SHIFT : one bit per cycle; count runs 0..WIDTH-1.
//            When count==WIDTH-1: out_last=1 (parity off), next -> IDLE.
//            With parity on, the next state is PARITY instead.
//    PARITY: one cycle; out_1 = even parity (XOR of the word); out_last=1.
//  - Back-to-back: in_ready is also 1 in the cycle whose bit has out_last=1.
//    An accept there starts the next frame with no gap. out_valid stays 1
//    and count restarts at 0.
//  - Idle line: out_1=0 whenever out_valid=0.
//  - WIDTH=1: each frame is one cycle, and out_valid and out_last are 1
//    together.
//  - Count register is $clog2(WIDTH)+1 bits wide; it never wraps mid-frame.
//  - Reset mid-frame aborts the frame: outputs go to reset values at once.
//    No partial bits resume afterwards; the aborted word is lost.
//  - in_valid may drop before accept without effect; no stalls mid-frame.
// CONFIGURATION
//  SIMPLE_SERIALIZER_PARITY_EN defined:
//    PARITY state is compiled in. Every frame gets one trailing even-parity
//    bit, and out_last moves to that bit.
//  Not defined:
//    PARITY state and its parity logic are absent. A frame is exactly
//    WIDTH bits.
// TESTING (WIDTH=8, MSB_FIRST=1 unless noted)
//  1 Reset: hold rst_n=0 for 3 cycles with in_valid=1.
//    -> in_ready=1; out_1=0, out_valid=0 and out_last=0 throughout.
//  2 Single word: accept 0xA5 on edge N.
//    -> cycles N+1..N+8 give out_1 = 1,0,1,0,0,1,0,1 with out_valid=1.
//    -> out_last=1 only at N+8; out_valid=0 at N+9.
//  3 LSB-first: MSB_FIRST=0, accept 0x01.
//    -> out_1 = 1,0,0,0,0,0,0,0.
//  4 Back-to-back: hold in_valid high with 0x0F then 0xF0.
//    -> 16 contiguous out_valid cycles with out_last at bits 8 and 16.
//    -> in_ready is high only in IDLE and on the out_last cycles.
//  5 Reset mid-frame: send 0xFF and pull rst_n low at bit 4.
//    -> outputs go to 0 the same cycle; after release, out_valid stays 0
//       until a new accept.
//  6 Parity (PARITY_EN defined): send 0x07.
//    -> 9 bits: 0,0,0,0,0,1,1,1,1, with out_last on bit 9.
//    -> 0x03 gives a trailing parity bit of 0.

Source files
------------

// File: rtl/simple_serializer.sv
// rtl/simple_serializer.sv - parallel-in, serial-out shifter for a 1-bit link
//
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit
// per clock on out_1, framed by out_valid and out_last.
//
// Optional feature macro: SIMPLE_SERIALIZER_PARITY_EN
//   defined   : each frame carries one trailing even-parity bit, which
//               also carries out_last.
//   undefined : a frame is exactly WIDTH bits, and no parity logic is built.
//
// Parameters:
//   WIDTH      data bits per frame (1..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word to send
//   in_ready   a word can be accepted on this edge
//   in_data    parallel word
//   out_1      serial data bit (0 while the line is idle)
//   out_valid  out_1 carries a frame bit
//   out_last   out_1 carries the final bit of the frame

module simple_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_1,
    output logic             out_valid,
    output logic             out_last
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             out_1_q, out_1_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             accept;
    logic             first_last;

`ifdef SIMPLE_SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Ready is decoded from registered state only: idle, or the cycle that
    // is presenting the final bit of a frame (back-to-back chaining).
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE:   in_ready = 1'b1;
`ifdef SIMPLE_SERIALIZER_PARITY_EN
            ST_SHIFT:  in_ready = 1'b0;
            ST_PARITY: in_ready = 1'b1;
`else
            ST_SHIFT:  in_ready = (count_q == LAST_CNT);
`endif
            default:   in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // With no parity bit, a one-bit frame ends on its first (only) bit.
`ifdef SIMPLE_SERIALIZER_PARITY_EN
    assign first_last = 1'b0;
`else
    assign first_last = (WIDTH == 1);
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        out_1_d     = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
`ifdef SIMPLE_SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif

        if (accept) begin
            // The first bit is registered straight from in_data so it shows
            // up the cycle after accept; shift_q keeps the remaining bits.
            state_d     = ST_SHIFT;
            count_d     = '0;
            out_valid_d = 1'b1;
            out_last_d  = first_last;
            if (MSB_FIRST != 0) begin
                out_1_d = in_data[WIDTH-1];
                shift_d = in_data << 1;
            end else begin
                out_1_d = in_data[0];
                shift_d = in_data >> 1;
            end
`ifdef SIMPLE_SERIALIZER_PARITY_EN
            parity_d = ^in_data;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (count_q != LAST_CNT) begin
                        count_d     = count_q + CW'(1);
                        out_valid_d = 1'b1;
`ifdef SIMPLE_SERIALIZER_PARITY_EN
                        out_last_d  = 1'b0;
`else
                        out_last_d  = ((count_q + CW'(1)) == LAST_CNT);
`endif
                        if (MSB_FIRST != 0) begin
                            out_1_d = shift_q[WIDTH-1];
                            shift_d = shift_q << 1;
                        end else begin
                            out_1_d = shift_q[0];
                            shift_d = shift_q >> 1;
                        end
                    end else begin
`ifdef SIMPLE_SERIALIZER_PARITY_EN
                        state_d     = ST_PARITY;
                        out_1_d     = parity_q;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
`else
                        state_d     = ST_IDLE;
                        count_d     = '0;
`endif
                    end
                end
`ifdef SIMPLE_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
`endif
                ST_IDLE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            out_1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            out_1_q     <= out_1_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef SIMPLE_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign out_1     = out_1_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_simple_serializer.sv
// tb/tb_simple_serializer.sv - self-checking bench for simple_serializer

module tb_simple_serializer;

    localparam int W = 8;
`ifdef SIMPLE_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;

    logic         in_valid, in_ready, out_1, out_valid, out_last;
    logic [W-1:0] in_data;

    logic         l_in_valid, l_in_ready, l_out_1, l_out_valid, l_out_last;
    logic [W-1:0] l_in_data;

    logic         w_in_valid, w_in_ready, w_out_1, w_out_valid, w_out_last;
    logic [0:0]   w_in_data;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    // Scoreboard entries are {bit, last} for the main (MSB-first) instance.
    logic [1:0] sb_q[$];

    simple_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_1(out_1), .out_valid(out_valid), .out_last(out_last)
    );

    simple_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_data(l_in_data), .out_1(l_out_1), .out_valid(l_out_valid), .out_last(l_out_last)
    );

    simple_serializer #(.WIDTH(1), .MSB_FIRST(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .out_1(w_out_1), .out_valid(w_out_valid), .out_last(w_out_last)
    );

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            sb_q.push_back({w[W-1-i], (i == W - 1) && (PAR == 0)});
        end
        if (PAR != 0) sb_q.push_back({^w, 1'b1});
    endfunction

    // Output monitor for the main instance.
    always @(negedge clk) begin
        logic [1:0] exp;
        if (mon_en && rst_n) begin
            n_checks++;
            if (in_ready !== (!out_valid || out_last)) begin
                n_fail++;
                $display("FAIL in_ready_decode got=%b exp=%b (out_valid=%b out_last=%b)",
                         in_ready, !out_valid || out_last, out_valid, out_last);
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_bit got out_valid=1 exp out_valid=0");
                end else begin
                    exp = sb_q.pop_front();
                    if ({out_1, out_last} !== exp) begin
                        n_fail++;
                        $display("FAIL serial_bit got {out_1,out_last}=%b exp=%b", {out_1, out_last}, exp);
                    end
                end
            end else begin
                n_checks++;
                if ({out_1, out_last, out_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL idle_line got {out_1,out_last,out_valid}=%b exp=000",
                             {out_1, out_last, out_valid});
                end
            end
        end
    end

    task automatic send_word(input logic [W-1:0] w, output bit got);
        got = 1'b0;
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < 40 && !got; c++) begin
            if (in_ready) begin
                push_word(w);
                got = 1'b1;
                @(posedge clk); #1;
            end else begin
                @(negedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;   in_data = 8'hA5;
        l_in_valid = 1'b1; l_in_data = 8'h5A;
        w_in_valid = 1'b1; w_in_data = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_1, out_valid, out_last} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_state got {in_ready,out_1,out_valid,out_last}=%b exp=1000",
                         {in_ready, out_1, out_valid, out_last});
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b0; l_in_valid = 1'b0; w_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got out_valid=%b exp=0", out_valid);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_word();
        bit got, ok;
        send_word(8'hA5, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL single_accept got=0 exp=1"); end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_1} !== 2'b11) begin
            n_fail++;
            $display("FAIL first_bit_latency got {out_valid,out_1}=%b exp=11", {out_valid, out_1});
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_drain got=timeout exp=drained"); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_end got out_valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [1:0] q[$];
        logic [W-1:0] w = 8'h01;
        for (int i = 0; i < W; i++) q.push_back({w[i], (i == W - 1) && (PAR == 0)});
        if (PAR != 0) q.push_back({^w, 1'b1});
        @(negedge clk);
        l_in_valid = 1'b1; l_in_data = w;
        @(posedge clk); #1;
        l_in_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            logic [1:0] exp;
            @(negedge clk);
            exp = q.pop_front();
            n_checks++;
            if ({l_out_valid, l_out_1, l_out_last} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d got {v,d,l}=%b exp=%b", i,
                         {l_out_valid, l_out_1, l_out_last}, {1'b1, exp});
            end
        end
        @(negedge clk);
        n_checks++;
        if (l_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_end got out_valid=%b exp=0", l_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[2] = '{8'h0F, 8'hF0};
        int idx = 0;
        int run = 0;
        bit done = 1'b0;
        bit ok;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk); #1;
            if (out_valid) run++;
            else if (run > 0) done = 1'b1;
            if (idx < 2) begin
                in_valid = 1'b1;
                in_data  = words[idx];
                if (in_ready) begin
                    push_word(words[idx]);
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (run != 2 * FRAME || idx != 2) begin
            n_fail++;
            $display("FAIL back_to_back_run got run=%0d words=%0d exp run=%0d words=2", run, idx, 2 * FRAME);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain got=timeout exp=drained"); end
    endtask

    task automatic test_random();
        bit got, ok;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(W'($urandom), got);
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL random_accept%0d got=0 exp=1", k); end
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL random_drain got=timeout exp=drained"); end
    endtask

    task automatic test_reset_mid_frame();
        bit got, ok;
        send_word(8'hFF, got);
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_active got out_valid=%b exp=1", out_valid);
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_1, out_valid, out_last} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midframe_reset got {in_ready,out_1,out_valid,out_last}=%b exp=1000",
                     {in_ready, out_1, out_valid, out_last});
        end
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL after_reset_idle got out_valid=%b exp=0", out_valid);
            end
        end
        send_word(8'h3C, got);
        wait_drain(ok);
        n_checks++;
        if (!got || !ok) begin n_fail++; $display("FAIL recovery got=%b%b exp=11", got, ok); end
    endtask

    task automatic test_width1();
        logic       pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] q[$];
        int pushed = 0;
        int seen   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (w_out_valid) begin
                logic [1:0] exp;
                seen++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL w1_unexpected got out_valid=1 exp=0");
                end else begin
                    exp = q.pop_front();
                    if ({w_out_1, w_out_last} !== exp) begin
                        n_fail++;
                        $display("FAIL w1_bit got {d,l}=%b exp=%b", {w_out_1, w_out_last}, exp);
                    end
                end
            end
            if (pushed < 4) begin
                w_in_valid = 1'b1;
                w_in_data  = pat[pushed];
                if (w_in_ready) begin
                    q.push_back({pat[pushed], PAR == 0});
                    if (PAR != 0) q.push_back({pat[pushed], 1'b1});
                    pushed++;
                end
            end else begin
                w_in_valid = 1'b0;
            end
        end
        n_checks++;
        if (seen != 4 * (1 + PAR) || q.size() != 0) begin
            n_fail++;
            $display("FAIL w1_count got seen=%0d left=%0d exp seen=%0d left=0", seen, q.size(), 4 * (1 + PAR));
        end
    endtask

`ifdef SIMPLE_SERIALIZER_PARITY_EN
    task automatic test_parity();
        bit got, ok;
        send_word(8'h07, got);
        send_word(8'h03, got);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL parity_drain got=timeout exp=drained"); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;   in_data = '0;
        l_in_valid = 1'b0; l_in_data = '0;
        w_in_valid = 1'b0; w_in_data = '0;
        test_reset();
        test_single_word();
        test_lsb_first();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_width1();
`ifdef SIMPLE_SERIALIZER_PARITY_EN
        test_parity();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
